mem_resp: RTL and testbench

//  MEM-stage response half of the data-SRAM path; sits directly after the data-request logic.

---
 rtl/cpu_defs.sv | 24 ++
 rtl/load_align.sv | 31 +++
 rtl/mem_resp.sv | 120 ++++++++++++
 tb/tb_mem_resp.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cpu_defs.sv
// cpu_defs: load-op bit indices and the outstanding-queue entry type (fwd macro MEM_RESP_FWD_EN lives in mem_resp)
package cpu_defs;
  localparam int LOP_LB  = 0;
  localparam int LOP_LBU = 1;
  localparam int LOP_LH  = 2;
  localparam int LOP_LHU = 3;
  localparam int LOP_LW  = 4;
  localparam int LOP_LWL = 5;
  localparam int LOP_LWR = 6;
  typedef struct packed {
    logic        is_load;
    logic [6:0]  load_op;
    logic [1:0]  addr_lo;
    logic [31:0] rt_old;
    logic [4:0]  dest;
    logic [31:0] pc;
  } mem_resp_meta_t;
  typedef struct packed {
    mem_resp_meta_t meta;
    logic [31:0]    rdata;
    logic           done;
    logic           killed;
  } mem_resp_entry_t;
endpackage

// File: rtl/load_align.sv
// load_align: (load_op, addr_lo, rdata, rt_old) -> aligned/extended/merged load result
module load_align
  import cpu_defs::*;
(
  input  logic [6:0]  load_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] rt_old,
  output logic [31:0] wdata
);
  logic [7:0]  b;
  logic [15:0] h;
  logic [31:0] lwl, lwr;
  always_comb begin
    b = rdata[{addr_lo, 3'b000} +: 8];
    h = rdata[{addr_lo[1], 4'b0000} +: 16];
    lwl = addr_lo == 2'd0 ? {rdata[7:0], rt_old[23:0]} :
          addr_lo == 2'd1 ? {rdata[15:0], rt_old[15:0]} :
          addr_lo == 2'd2 ? {rdata[23:0], rt_old[7:0]} : rdata;
    lwr = addr_lo == 2'd0 ? rdata :
          addr_lo == 2'd1 ? {rt_old[31:24], rdata[31:8]} :
          addr_lo == 2'd2 ? {rt_old[31:16], rdata[31:16]} : {rt_old[31:8], rdata[31:24]};
    wdata = load_op[LOP_LB]  ? {{24{b[7]}}, b} :
            load_op[LOP_LBU] ? {24'b0, b} :
            load_op[LOP_LH]  ? {{16{h[15]}}, h} :
            load_op[LOP_LHU] ? {16'b0, h} :
            load_op[LOP_LW]  ? rdata :
            load_op[LOP_LWL] ? lwl :
            load_op[LOP_LWR] ? lwr : 32'b0;
  end
endmodule

// File: rtl/mem_resp.sv
// mem_resp: in-order data-SRAM response queue with load alignment and WB handshake; MEM_RESP_FWD_EN adds fwd_* bypass ports
module mem_resp
  import cpu_defs::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_load,
  input  logic [6:0]  req_load_op,
  input  logic [1:0]  req_addr_lo,
  input  logic [31:0] req_rt_old,
  input  logic [4:0]  req_dest,
  input  logic [31:0] req_pc,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  input  logic        flush,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_we,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_wdata,
  output logic [31:0] wb_pc
`ifdef MEM_RESP_FWD_EN
  ,
  output logic        fwd_valid,
  output logic [4:0]  fwd_dest,
  output logic [31:0] fwd_data
`endif
);
  localparam int PW = $clog2(DEPTH);
  mem_resp_entry_t entry_q [DEPTH];
  mem_resp_entry_t entry_d [DEPTH];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d, resp_q, resp_d;
  logic [PW:0]   count_q, count_d, ndone_q, ndone_d;
  logic          wb_valid_q, wb_valid_d, wb_we_q, wb_we_d;
  logic [4:0]    wb_dest_q, wb_dest_d;
  logic [31:0]   wb_wdata_q, wb_wdata_d, wb_pc_q, wb_pc_d;
  mem_resp_entry_t head;
  logic          push, ok_hit, head_fire, head_kill, pop, load_out;
  logic [31:0]   head_rdata, head_wdata;
  assign req_ready = count_q != (PW+1)'(DEPTH);
  assign head = entry_q[head_q];
  assign head_rdata = head.done ? head.rdata : data_rdata;
  load_align u_align (
    .load_op(head.meta.load_op),
    .addr_lo(head.meta.addr_lo),
    .rdata  (head_rdata),
    .rt_old (head.meta.rt_old),
    .wdata  (head_wdata)
  );
  always_comb begin
    push = req_valid && req_ready && !flush;
    ok_hit = data_data_ok && ndone_q != '0;
    head_fire = count_q != '0 && (head.done || (ok_hit && resp_q == head_q));
    head_kill = head.killed || flush;
    load_out = head_fire && !head_kill && (!wb_valid_q || wb_ready);
    pop = head_fire && (head_kill || !wb_valid_q || wb_ready);
    entry_d = entry_q;
    if (ok_hit) begin
      entry_d[resp_q].rdata = data_rdata;
      entry_d[resp_q].done = 1'b1;
    end
    if (flush)
      for (int i = 0; i < DEPTH; i++) entry_d[i].killed = 1'b1;
    if (push)
      entry_d[tail_q] = '{meta: '{req_is_load, req_load_op, req_addr_lo, req_rt_old, req_dest, req_pc},
                          rdata: 32'b0, done: 1'b0, killed: 1'b0};
    head_d = pop ? head_q + PW'(1) : head_q;
    tail_d = push ? tail_q + PW'(1) : tail_q;
    resp_d = ok_hit ? resp_q + PW'(1) : resp_q;
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
    ndone_d = ndone_q + (PW+1)'(push) - (PW+1)'(ok_hit);
    wb_valid_d = flush ? 1'b0 : load_out ? 1'b1 : wb_valid_q && !wb_ready;
    wb_we_d = load_out ? head.meta.is_load : wb_we_q;
    wb_dest_d = load_out ? head.meta.dest : wb_dest_q;
    wb_wdata_d = load_out ? (head.meta.is_load ? head_wdata : 32'b0) : wb_wdata_q;
    wb_pc_d = load_out ? head.meta.pc : wb_pc_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      resp_q <= '0;
      count_q <= '0;
      ndone_q <= '0;
      wb_valid_q <= 1'b0;
      wb_we_q <= 1'b0;
      wb_dest_q <= 5'b0;
      wb_wdata_q <= 32'b0;
      wb_pc_q <= 32'b0;
    end else begin
      entry_q <= entry_d;
      head_q <= head_d;
      tail_q <= tail_d;
      resp_q <= resp_d;
      count_q <= count_d;
      ndone_q <= ndone_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q <= wb_we_d;
      wb_dest_q <= wb_dest_d;
      wb_wdata_q <= wb_wdata_d;
      wb_pc_q <= wb_pc_d;
    end
  end
  assert property (@(posedge clk) disable iff (reset) data_data_ok |-> ndone_q != '0);
  assign wb_valid = wb_valid_q;
  assign wb_we = wb_we_q;
  assign wb_dest = wb_dest_q;
  assign wb_wdata = wb_wdata_q;
  assign wb_pc = wb_pc_q;
`ifdef MEM_RESP_FWD_EN
  assign fwd_valid = wb_valid_q && wb_we_q;
  assign fwd_dest = wb_dest_q;
  assign fwd_data = wb_wdata_q;
`endif
endmodule

// File: tb/tb_mem_resp.sv
// tb_mem_resp: directed self-checking bench for mem_resp
module tb_mem_resp;
  logic        clk, reset, req_valid, req_ready, req_is_load;
  logic [6:0]  req_load_op;
  logic [1:0]  req_addr_lo;
  logic [31:0] req_rt_old, req_pc, data_rdata, wb_wdata, wb_pc;
  logic [4:0]  req_dest, wb_dest;
  logic        data_data_ok, flush, wb_valid, wb_ready, wb_we;
  int n_chk = 0, n_fail = 0;
  mem_resp dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_is_load(req_is_load), .req_load_op(req_load_op), .req_addr_lo(req_addr_lo),
    .req_rt_old(req_rt_old), .req_dest(req_dest), .req_pc(req_pc),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata), .flush(flush),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we), .wb_dest(wb_dest),
    .wb_wdata(wb_wdata), .wb_pc(wb_pc)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk)
    if (!reset && req_valid && !req_ready) begin
      n_fail++;
      $display("FAIL proto req_valid while req_ready=0 at %0t", $time);
    end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic issue(input logic ld, input logic [6:0] op, input logic [1:0] a,
                       input logic [31:0] t, input logic [4:0] d, input logic [31:0] pc, input logic fl);
    req_valid = 1'b1; req_is_load = ld; req_load_op = op; req_addr_lo = a;
    req_rt_old = t; req_dest = d; req_pc = pc; flush = fl;
    tick;
    req_valid = 1'b0; flush = 1'b0;
  endtask
  task automatic resp(input logic [31:0] r, input logic fl);
    data_data_ok = 1'b1; data_rdata = r; flush = fl;
    tick;
    data_data_ok = 1'b0; flush = 1'b0;
  endtask
  task automatic load_chk(input string tag, input logic [6:0] op, input logic [1:0] a,
                          input logic [31:0] t, input logic [31:0] r, input logic [31:0] exp);
    issue(1'b1, op, a, t, 5'd7, 32'h1000, 1'b0);
    resp(r, 1'b0);
    check({tag, "_v"}, wb_valid, 1);
    check(tag, wb_wdata, exp);
    tick;
  endtask
  initial begin
    reset = 1'b1; req_valid = 1'b0; req_is_load = 1'b0; req_load_op = '0; req_addr_lo = '0;
    req_rt_old = '0; req_dest = '0; req_pc = '0; data_data_ok = 1'b0; data_rdata = '0;
    flush = 1'b0; wb_ready = 1'b1;
    tick; tick;
    reset = 1'b0;
    tick;
    check("rst_valid", wb_valid, 0);
    check("rst_we", wb_we, 0);
    check("rst_dest", wb_dest, 0);
    check("rst_wdata", wb_wdata, 0);
    check("rst_pc", wb_pc, 0);
    check("rst_ready", req_ready, 1);
    issue(1'b1, 7'b0000001, 2'd3, 32'h0, 5'd5, 32'h100, 1'b0);
    resp(32'h80FF_1234, 1'b0);
    check("lb_valid", wb_valid, 1);
    check("lb_data", wb_wdata, 32'hFFFF_FF80);
    check("lb_we", wb_we, 1);
    check("lb_dest", wb_dest, 5);
    check("lb_pc", wb_pc, 32'h100);
    tick;
    check("lb_drain", wb_valid, 0);
    load_chk("lbu", 7'b0000010, 2'd3, 32'h0, 32'h80FF_1234, 32'h0000_0080);
    load_chk("lh", 7'b0000100, 2'd2, 32'h0, 32'h8001_1234, 32'hFFFF_8001);
    load_chk("lhu", 7'b0001000, 2'd0, 32'h0, 32'h8001_9234, 32'h0000_9234);
    load_chk("lw", 7'b0010000, 2'd0, 32'h0, 32'h1357_9BDF, 32'h1357_9BDF);
    load_chk("lwl1", 7'b0100000, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'h3344_CCDD);
    load_chk("lwl0", 7'b0100000, 2'd0, 32'hAABB_CCDD, 32'h1122_3344, 32'h44BB_CCDD);
    load_chk("lwr1", 7'b1000000, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 32'hAA11_2233);
    load_chk("lwr3", 7'b1000000, 2'd3, 32'hAABB_CCDD, 32'h1122_3344, 32'hAABB_CC11);
    issue(1'b0, 7'b0, 2'd0, 32'h0, 5'd3, 32'h200, 1'b0);
    resp(32'hDEAD_BEEF, 1'b0);
    check("st_valid", wb_valid, 1);
    check("st_we", wb_we, 0);
    check("st_wdata", wb_wdata, 0);
    check("st_pc", wb_pc, 32'h200);
    tick;
    wb_ready = 1'b0;
    issue(1'b1, 7'b0010000, 2'd0, 32'h0, 5'd1, 32'h300, 1'b0);
    check("bp_ready1", req_ready, 1);
    issue(1'b1, 7'b0010000, 2'd0, 32'h0, 5'd2, 32'h304, 1'b0);
    check("bp_full", req_ready, 0);
    resp(32'h1111_1111, 1'b0);
    check("bp_v1", wb_valid, 1);
    check("bp_d1", wb_wdata, 32'h1111_1111);
    resp(32'h2222_2222, 1'b0);
    tick; tick;
    check("bp_hold_v", wb_valid, 1);
    check("bp_hold_d", wb_wdata, 32'h1111_1111);
    check("bp_hold_pc", wb_pc, 32'h300);
    wb_ready = 1'b1;
    tick;
    check("bp_v2", wb_valid, 1);
    check("bp_d2", wb_wdata, 32'h2222_2222);
    check("bp_dest2", wb_dest, 2);
    tick;
    check("bp_empty", wb_valid, 0);
    check("bp_ready", req_ready, 1);
    issue(1'b1, 7'b0010000, 2'd0, 32'h0, 5'd4, 32'h400, 1'b0);
    issue(1'b1, 7'b0010000, 2'd0, 32'h0, 5'd5, 32'h404, 1'b0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    tick; tick; tick;
    resp(32'hAAAA_0001, 1'b0);
    check("fl_v1", wb_valid, 0);
    resp(32'hAAAA_0002, 1'b0);
    check("fl_v2", wb_valid, 0);
    tick;
    check("fl_v3", wb_valid, 0);
    check("fl_ready", req_ready, 1);
    issue(1'b1, 7'b0010000, 2'd0, 32'h0, 5'd6, 32'h500, 1'b0);
    resp(32'hCAFE_F00D, 1'b0);
    check("fl_new_d", wb_wdata, 32'hCAFE_F00D);
    check("fl_new_pc", wb_pc, 32'h500);
    tick;
    issue(1'b1, 7'b0010000, 2'd0, 32'h0, 5'd8, 32'h600, 1'b0);
    issue(1'b1, 7'b0010000, 2'd0, 32'h0, 5'd9, 32'h604, 1'b1);
    resp(32'hBBBB_0001, 1'b0);
    check("drop_v", wb_valid, 0);
    issue(1'b1, 7'b0010000, 2'd0, 32'h0, 5'd10, 32'h700, 1'b0);
    resp(32'hBBBB_0002, 1'b0);
    check("drop_pc", wb_pc, 32'h700);
    check("drop_d", wb_wdata, 32'hBBBB_0002);
    tick;
    issue(1'b1, 7'b0010000, 2'd0, 32'h0, 5'd11, 32'h800, 1'b0);
    resp(32'hCCCC_0001, 1'b1);
    check("okfl_v", wb_valid, 0);
    tick;
    check("okfl_v2", wb_valid, 0);
    issue(1'b1, 7'b0010000, 2'd0, 32'h0, 5'd12, 32'h804, 1'b0);
    resp(32'hCCCC_0002, 1'b0);
    check("okfl_pc", wb_pc, 32'h804);
    check("okfl_d", wb_wdata, 32'hCCCC_0002);
    tick;
    issue(1'b1, 7'b0010000, 2'd0, 32'h0, 5'd13, 32'h900, 1'b0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("mrst_v", wb_valid, 0);
    check("mrst_ready", req_ready, 1);
    check("mrst_pc", wb_pc, 0);
    issue(1'b1, 7'b0010000, 2'd0, 32'h0, 5'd14, 32'hA00, 1'b0);
    resp(32'hDDDD_0001, 1'b0);
    check("mrst_new_pc", wb_pc, 32'hA00);
    check("mrst_new_d", wb_wdata, 32'hDDDD_0001);
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
